// File: rtl/sr_pc_if.sv
// sr_pc_if: decoder/fetch-side bundle of the bit-serial PC unit.
// W is the digit width and must match the W of the attached sr_pc_unit.
interface sr_pc_if #(
    parameter int W = 1
);
    logic          i_boot_mode;
    logic          i_start;
    logic          i_jump;
    logic          i_jal_or_jalr;
    logic          i_utype;
    logic          i_pc_rel;
    logic          i_trap;
    logic          i_iscomp;
    logic [W-1:0]  i_imm;
    logic [W-1:0]  i_buf;
    logic [W-1:0]  i_csr_pc;
    logic [W-1:0]  o_rd;
    logic          o_busy;
    logic          o_done;
    logic          o_bad_pc;
    logic [31:0]   o_ibus_adr;

    // Core/decoder side
    modport master (
        output i_boot_mode, i_start, i_jump, i_jal_or_jalr, i_utype, i_pc_rel,
               i_trap, i_iscomp, i_imm, i_buf, i_csr_pc,
        input  o_rd, o_busy, o_done, o_bad_pc, o_ibus_adr
    );

    // PC unit side
    modport slave (
        input  i_boot_mode, i_start, i_jump, i_jal_or_jalr, i_utype, i_pc_rel,
               i_trap, i_iscomp, i_imm, i_buf, i_csr_pc,
        output o_rd, o_busy, o_done, o_bad_pc, o_ibus_adr
    );
endinterface

// File: rtl/sr_pc_unit.sv
// sr_pc_unit: bit-serial program counter, W bits per cycle over 32/W cycles.
// Computes PC+inc, jump/branch/U-type target and trap vector digit by digit,
// streams the link/AUIPC value on o_rd and commits the new PC at pass end.
// Optional feature macro: SR_PC_COMPRESSED_EN (INC=2 for compressed
// instructions, 2-byte target alignment so o_bad_pc never sets).
module sr_pc_unit #(
    parameter int          W        = 1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BOOT_PC  = 32'h0000_8000
) (
    input  logic   clk,
    input  logic   i_rst,
    sr_pc_if.slave bus
);
    localparam int N  = 32 / W;
    localparam int KW = $clog2(N);
    localparam int S  = 32 - W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k;
    logic [31:0]     pc_q;
    logic [S-1:0]    shadow;
    logic            bad_q;
    logic            jump_q, jal_q, utype_q, pc_rel_q, trap_q;
    logic            c_inc, c_tgt, c_inc_nxt, c_tgt_nxt;
    logic [4:0]      base;
    logic [4:0]      inc_pos;
    logic [W-1:0]    pc_dig, new_dig, rd_dig;
    logic [31:0]     commit_pc;
    logic            last, start_ok;

`ifdef SR_PC_COMPRESSED_EN
    logic            comp_q;
    assign inc_pos = comp_q ? 5'd1 : 5'd2;
`else
    logic            unused_iscomp;
    assign unused_iscomp = bus.i_iscomp;
    assign inc_pos       = 5'd2;
`endif

    assign base      = 5'(32'(k) * 32'(W));
    assign pc_dig    = pc_q[base +: W];
    assign last      = (k == KW'(N - 1));
    assign start_ok  = (state == IDLE) && bus.i_start;
    // Shadow holds the digits produced so far, newest at the top
    assign commit_pc = {new_dig, shadow};

    // Per-lane serial adders: PC+INC, target, and the writeback/next-PC mux
    always_comb begin
        logic       ci, ct, p, ib, inc_b, off, a, tgt_b, csr_b;
        logic [4:0] b;
        ci      = c_inc;
        ct      = c_tgt;
        new_dig = '0;
        rd_dig  = '0;
        for (int j = 0; j < W; j++) begin
            b     = base + 5'(j);
            p     = pc_dig[j];
            ib    = (b == inc_pos);
            inc_b = p ^ ib ^ ci;
            ci    = (p & ib) | (ci & (p ^ ib));
            off   = utype_q ? ((b >= 5'd12) & bus.i_imm[j]) : bus.i_buf[j];
            a     = pc_rel_q & p;
            tgt_b = (a ^ off ^ ct) & (b != 5'd0);
            ct    = (a & off) | (ct & (a ^ off));
            csr_b = bus.i_csr_pc[j] & (b != 5'd0);
            new_dig[j] = trap_q ? csr_b : (jump_q ? tgt_b : inc_b);
            rd_dig[j]  = (utype_q & tgt_b) | (jal_q & inc_b);
        end
        c_inc_nxt = ci;
        c_tgt_nxt = ct;
    end

    // State register
    always_ff @(posedge clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: a pass runs N digits, then a single DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_start) state_nxt = RUN;
            RUN:     if (last)        state_nxt = DONE;
            DONE:                     state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Control latch, digit counter, carries, shadow and PC commit
    always_ff @(posedge clk) begin
        if (i_rst) begin
            pc_q     <= bus.i_boot_mode ? BOOT_PC : RESET_PC;
            bad_q    <= 1'b0;
            k        <= '0;
            c_inc    <= 1'b0;
            c_tgt    <= 1'b0;
            shadow   <= '0;
            jump_q   <= 1'b0;
            jal_q    <= 1'b0;
            utype_q  <= 1'b0;
            pc_rel_q <= 1'b0;
            trap_q   <= 1'b0;
`ifdef SR_PC_COMPRESSED_EN
            comp_q   <= 1'b0;
`endif
        end else if (start_ok) begin
            jump_q   <= bus.i_jump;
            jal_q    <= bus.i_jal_or_jalr;
            utype_q  <= bus.i_utype;
            pc_rel_q <= bus.i_pc_rel;
            trap_q   <= bus.i_trap;
`ifdef SR_PC_COMPRESSED_EN
            comp_q   <= bus.i_iscomp;
`endif
            k        <= '0;
            c_inc    <= 1'b0;
            c_tgt    <= 1'b0;
        end else if (state == RUN) begin
            k      <= k + 1'b1;
            c_inc  <= c_inc_nxt;
            c_tgt  <= c_tgt_nxt;
            shadow <= commit_pc[31:W];
            if (last) begin
                pc_q <= commit_pc;
`ifndef SR_PC_COMPRESSED_EN
                // Taken non-trap target must be 4-byte aligned
                bad_q <= bad_q | (jump_q & ~trap_q & commit_pc[1]);
`endif
            end
        end
    end

    assign bus.o_busy     = (state == RUN);
    assign bus.o_done     = (state == DONE);
    assign bus.o_rd       = (state == RUN) ? rd_dig : '0;
    assign bus.o_bad_pc   = bad_q;
    assign bus.o_ibus_adr = pc_q;
endmodule

// File: tb/tb_sr_pc_unit.sv
// tb_sr_pc_unit: directed and random passes of sr_pc_unit (W=4) against a
// whole-word arithmetic reference model of the PC update.
module tb_sr_pc_unit;
    localparam int          W        = 4;
    localparam int          N        = 32 / W;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] BOOT_PC  = 32'h0000_8000;
`ifdef SR_PC_COMPRESSED_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    typedef struct {
        bit jump, jal, utype, pc_rel, trap, comp;
        logic [31:0] imm, bufv, csr;
    } pass_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] m_pc;
    logic        m_bad;

    sr_pc_if #(.W(W)) bus();
    sr_pc_unit #(.W(W), .RESET_PC(RESET_PC), .BOOT_PC(BOOT_PC)) dut (
        .clk(clk), .i_rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: whole-word arithmetic, modulo 2^32
    task automatic model_pass(input pass_t p, output logic [31:0] rd_exp);
        logic [31:0] inc, tgt, nxt;
        inc    = m_pc + ((COMP && p.comp) ? 32'd2 : 32'd4);
        tgt    = ((p.pc_rel ? m_pc : 32'd0) + (p.utype ? {p.imm[31:12], 12'h0} : p.bufv)) & ~32'd1;
        nxt    = p.trap ? (p.csr & ~32'd1) : (p.jump ? tgt : inc);
        rd_exp = (p.utype ? tgt : 32'd0) | (p.jal ? inc : 32'd0);
        if (!COMP && p.jump && !p.trap && tgt[1]) m_bad = 1'b1;
        m_pc   = nxt;
    endtask

    // Drive one pass; controls are scrambled after the start edge
    task automatic run_pass(input pass_t p, output logic [31:0] rd_obs,
                            output bit busy_ok, output bit done_ok);
        logic [31:0] pc_hold;
        pc_hold = m_pc;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_jump = p.jump; bus.i_jal_or_jalr = p.jal; bus.i_utype = p.utype;
        bus.i_pc_rel = p.pc_rel; bus.i_trap = p.trap; bus.i_iscomp = p.comp;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        {bus.i_jump, bus.i_jal_or_jalr, bus.i_utype, bus.i_pc_rel, bus.i_trap, bus.i_iscomp} = 6'($urandom);
        busy_ok = 1'b1;
        rd_obs  = '0;
        for (int k = 0; k < N; k++) begin
            bus.i_imm    = p.imm[k*W +: W];
            bus.i_buf    = p.bufv[k*W +: W];
            bus.i_csr_pc = p.csr[k*W +: W];
            @(negedge clk);
            rd_obs[k*W +: W] = bus.o_rd;
            if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0 || bus.o_ibus_adr !== pc_hold) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        bus.i_imm = W'($urandom); bus.i_buf = W'($urandom); bus.i_csr_pc = W'($urandom);
        @(negedge clk);
        done_ok = (bus.o_done === 1'b1) && (bus.o_busy === 1'b0) && (bus.o_rd === '0);
    endtask

    task automatic set_pc(input logic [31:0] val);
        pass_t p; logic [31:0] r, e; bit b, d;
        p = '{default: 0};
        p.jump = 1'b1; p.bufv = val;
        run_pass(p, r, b, d);
        model_pass(p, e);
    endtask

    task automatic do_reset(input bit boot);
        @(negedge clk);
        rst = 1'b1; bus.i_boot_mode = boot; bus.i_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_pc  = boot ? BOOT_PC : RESET_PC;
        m_bad = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++; if (bus.o_ibus_adr !== 32'h0000_8000) begin failures++; $display("FAIL reset_boot_pc: got %h expected %h", bus.o_ibus_adr, 32'h8000); end
        do_reset(1'b0);
        checks++; if (bus.o_ibus_adr !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected %h", bus.o_ibus_adr, 32'h0); end
        checks++; if ({bus.o_busy, bus.o_done, bus.o_bad_pc} !== 3'b000 || bus.o_rd !== '0) begin failures++; $display("FAIL reset_outputs: got busy/done/bad=%b%b%b rd=%h expected 0", bus.o_busy, bus.o_done, bus.o_bad_pc, bus.o_rd); end
    endtask

    task automatic test_sequential();
        pass_t p; logic [31:0] r, e, exp_pc; bit b, d;
        set_pc(32'h100);
        p = '{default: 0}; p.comp = 1'b1; p.imm = $urandom; p.bufv = $urandom; p.csr = $urandom;
        run_pass(p, r, b, d); model_pass(p, e);
        exp_pc = COMP ? 32'h102 : 32'h104;
        checks++; if (bus.o_ibus_adr !== exp_pc) begin failures++; $display("FAIL seq_pc: got %h expected %h", bus.o_ibus_adr, exp_pc); end
        checks++; if (!(b && d)) begin failures++; $display("FAIL seq_timing: got busy_ok=%0d done_ok=%0d expected 1 1", b, d); end
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL seq_rd: got %h expected 0", r); end
    endtask

    task automatic test_jal();
        pass_t p; logic [31:0] r, e; bit b, d;
        set_pc(32'h1000);
        p = '{default: 0}; p.jump = 1'b1; p.jal = 1'b1; p.pc_rel = 1'b1; p.bufv = 32'h800; p.imm = $urandom;
        run_pass(p, r, b, d); model_pass(p, e);
        checks++; if (r !== 32'h1004) begin failures++; $display("FAIL jal_rd: got %h expected %h", r, 32'h1004); end
        checks++; if (bus.o_ibus_adr !== 32'h1800) begin failures++; $display("FAIL jal_pc: got %h expected %h", bus.o_ibus_adr, 32'h1800); end
        checks++; if (!(b && d)) begin failures++; $display("FAIL jal_timing: got %0d %0d expected 1 1", b, d); end
    endtask

    task automatic test_auipc();
        pass_t p; logic [31:0] r, e; bit b, d;
        set_pc(32'h1000);
        p = '{default: 0}; p.utype = 1'b1; p.pc_rel = 1'b1; p.imm = 32'h1234_5FFF; p.bufv = $urandom;
        run_pass(p, r, b, d); model_pass(p, e);
        checks++; if (r !== 32'h1234_6000) begin failures++; $display("FAIL auipc_rd: got %h expected %h", r, 32'h12346000); end
        checks++; if (bus.o_ibus_adr !== 32'h1004) begin failures++; $display("FAIL auipc_pc: got %h expected %h", bus.o_ibus_adr, 32'h1004); end
    endtask

    task automatic test_trap();
        pass_t p; logic [31:0] r, e; bit b, d;
        p = '{default: 0}; p.trap = 1'b1; p.jump = 1'b1; p.csr = 32'h8000_0001; p.bufv = 32'h2;
        run_pass(p, r, b, d); model_pass(p, e);
        checks++; if (bus.o_ibus_adr !== 32'h8000_0000) begin failures++; $display("FAIL trap_pc: got %h expected %h", bus.o_ibus_adr, 32'h80000000); end
        checks++; if (bus.o_bad_pc !== 1'b0) begin failures++; $display("FAIL trap_bad: got %b expected 0", bus.o_bad_pc); end
    endtask

    task automatic test_wrap();
        pass_t p; logic [31:0] r, e; bit b, d;
        set_pc(32'hFFFF_FFFC);
        p = '{default: 0}; p.jal = 1'b1;
        run_pass(p, r, b, d); model_pass(p, e);
        checks++; if (bus.o_ibus_adr !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h expected 0", bus.o_ibus_adr); end
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL wrap_rd: got %h expected 0", r); end
    endtask

    task automatic test_bad_pc();
        pass_t p; logic [31:0] r, e; bit b, d; logic exp_bad;
        exp_bad = !COMP;
        p = '{default: 0}; p.jump = 1'b1; p.bufv = 32'h1002;
        run_pass(p, r, b, d); model_pass(p, e);
        checks++; if (bus.o_ibus_adr !== 32'h1002) begin failures++; $display("FAIL bad_target_pc: got %h expected %h", bus.o_ibus_adr, 32'h1002); end
        checks++; if (bus.o_bad_pc !== exp_bad) begin failures++; $display("FAIL bad_set: got %b expected %b", bus.o_bad_pc, exp_bad); end
        p = '{default: 0};
        run_pass(p, r, b, d); model_pass(p, e);
        checks++; if (bus.o_bad_pc !== exp_bad) begin failures++; $display("FAIL bad_sticky: got %b expected %b", bus.o_bad_pc, exp_bad); end
    endtask

    task automatic test_back_to_back();
        pass_t p; logic [31:0] r, e; bit b, d;
        set_pc(32'h2000);
        p = '{default: 0};
        run_pass(p, r, b, d); model_pass(p, e);
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL start_in_done: got busy=%b expected 0", bus.o_busy); end
        p.jal = 1'b1;
        run_pass(p, r, b, d); model_pass(p, e);
        checks++; if (bus.o_ibus_adr !== 32'h2008 || r !== 32'h2008 || !(b && d)) begin failures++; $display("FAIL b2b_pass: got pc=%h rd=%h ok=%0d%0d expected %h %h 11", bus.o_ibus_adr, r, b, d, 32'h2008, 32'h2008); end
    endtask

    task automatic test_reset_midpass();
        bit saw_done;
        set_pc(32'h1234_5670);
        bus.i_boot_mode = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1; {bus.i_jump, bus.i_jal_or_jalr, bus.i_utype, bus.i_pc_rel, bus.i_trap} = '0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = RESET_PC; m_bad = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin failures++; $display("FAIL midreset_busy: got busy=%b done=%b expected 0 0", bus.o_busy, bus.o_done); end
        checks++; if (bus.o_ibus_adr !== RESET_PC) begin failures++; $display("FAIL midreset_pc: got %h expected %h", bus.o_ibus_adr, RESET_PC); end
        checks++; if (bus.o_bad_pc !== 1'b0) begin failures++; $display("FAIL midreset_bad: got %b expected 0", bus.o_bad_pc); end
        saw_done = 1'b0;
        repeat (N + 2) begin @(negedge clk); if (bus.o_done !== 1'b0) saw_done = 1'b1; end
        checks++; if (saw_done) begin failures++; $display("FAIL midreset_done: got done pulse expected none"); end
    endtask

    task automatic test_start_with_reset();
        set_pc(32'h400);
        @(negedge clk);
        rst = 1'b1; bus.i_start = 1'b1; bus.i_boot_mode = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.i_start = 1'b0;
        m_pc = BOOT_PC; m_bad = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0 || bus.o_ibus_adr !== BOOT_PC) begin failures++; $display("FAIL start_vs_reset: got busy=%b pc=%h expected 0 %h", bus.o_busy, bus.o_ibus_adr, BOOT_PC); end
    endtask

    task automatic test_random();
        pass_t p; logic [31:0] r, e; bit b, d;
        for (int i = 0; i < 40; i++) begin
            p.jump = 1'($urandom); p.jal = 1'($urandom); p.utype = 1'($urandom);
            p.pc_rel = 1'($urandom); p.trap = ($urandom_range(0, 7) == 0); p.comp = 1'($urandom);
            p.imm = $urandom; p.bufv = $urandom; p.csr = $urandom;
            if (i % 4 == 0) p.bufv = p.bufv & ~32'h3;
            run_pass(p, r, b, d); model_pass(p, e);
            checks++; if (r !== e) begin failures++; $display("FAIL rand_rd[%0d]: got %h expected %h", i, r, e); end
            checks++; if (bus.o_ibus_adr !== m_pc) begin failures++; $display("FAIL rand_pc[%0d]: got %h expected %h", i, bus.o_ibus_adr, m_pc); end
            checks++; if (bus.o_bad_pc !== m_bad) begin failures++; $display("FAIL rand_bad[%0d]: got %b expected %b", i, bus.o_bad_pc, m_bad); end
            checks++; if (!(b && d)) begin failures++; $display("FAIL rand_timing[%0d]: got %0d %0d expected 1 1", i, b, d); end
        end
    endtask

    initial begin
        bus.i_boot_mode = 1'b0; bus.i_start = 1'b0; bus.i_jump = 1'b0; bus.i_jal_or_jalr = 1'b0;
        bus.i_utype = 1'b0; bus.i_pc_rel = 1'b0; bus.i_trap = 1'b0; bus.i_iscomp = 1'b0;
        bus.i_imm = '0; bus.i_buf = '0; bus.i_csr_pc = '0;
        m_pc = RESET_PC; m_bad = 1'b0;
        test_reset();
        test_sequential();
        test_jal();
        test_auipc();
        test_trap();
        test_wrap();
        test_bad_pc();
        test_back_to_back();
        test_reset_midpass();
        test_start_with_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
